cm150_sel_scheduler: RTL and testbench
======================================

// Module: cm150_sel_scheduler
// PURPOSE
//  Round-robin scheduler that shares one 16:1 mux among 16 requesters.
//  - Drives the mux's 4 select lines and its disable line.
//  - Minimises select toggling for power: select lines only move when the grant changes owner.
//  - Forces the mux output inactive while the select lines settle, so no glitched data
//    reaches the consumer.
//  - Counts select changes so the switching activity of the shared mux can be measured.
// PARAMETERS
//  SETTLE    2   cycles mux_dis is held high after sel changes, before a grant (>=1)
//  MAX_HOLD  8   max consecutive grant cycles while another requester is waiting (>=1)
//  CNT_W     16  width of the saturating select-change counter
// PORTS
//  clk      in   1      rising-edge clock
//  rst      in   1      asynchronous reset, active-high
//  req      in   16     request per mux data input; bit i requests input i
//  cnt_clr  in   1      synchronous clear of sw_cnt
//  sel      out  4      mux select {t,s,r,q}; q is the LSB
//  mux_dis  out  1      to the mux enable u; 1 forces the mux output to 1 (disabled)
//  gnt      out  16     one-hot grant; bit sel is set while granted
//  gnt_vld  out  1      1 while a grant is active (equals ~mux_dis)
//  sw_cnt   out  CNT_W  saturating count of sel value changes
// BEHAVIOUR
//  Clock/reset: single clock clk; rst is asynchronous, active-high; all outputs registered.
//  Reset values:
//  - sel=0, mux_dis=1, gnt=0, gnt_vld=0, sw_cnt=0
//  - state=IDLE, rr pointer ptr=0, hold counter=0.
//  Arbitration: winner = first set req bit at index ptr, ptr+1, ... (mod 16).
//  IDLE:
//  - req==0: stay in IDLE; sel holds its value (no toggling); mux_dis=1.
//  - winner==sel: next edge goes to GRANT. gnt/gnt_vld/mux_dis=0 are visible 1 cycle after req.
//  - winner!=sel: next edge loads sel<=winner, sw_cnt+1, goes to SWITCH with mux_dis=1.
//  SWITCH:
//  - Lasts SETTLE cycles, then goes to GRANT. Grant is visible SETTLE+1 cycles after req.
//  - req changes during SWITCH are ignored; the already-chosen winner is granted.
//  GRANT:
//  - On entry: gnt=1<<sel, mux_dis=0, hold counter=MAX_HOLD.
//  - Hold counter decrements each cycle.
//  - Exit when req[sel] drops, or when the hold counter reaches 0 while any other req bit is set.
//  - On exit, next edge: gnt=0, mux_dis=1, ptr<=sel+1 (mod 16), go to IDLE.
//    IDLE re-arbitrates on the following cycle.
//  - Counter reaches 0 with no other requester: counter reloads and the grant continues (no gap).
//  - req[sel] dropping and hold expiry on the same cycle are a single exit event.
//  sw_cnt:
//  - +1 on each cycle sel changes value; saturates at all-ones.
//  - cnt_clr has priority over an increment on the same cycle (result 0).
//  Reset mid-operation: all state returns to reset values immediately (asynchronous).
//  - mux_dis=1 protects the consumer.
//  Invariants:
//  - gnt is 0 or one-hot, and equals 1<<sel whenever gnt_vld=1.
//  - sel never changes while mux_dis=0.
//  - mux_dis=1 on every cycle sel changes and for the SETTLE cycles after it.
//  Expected size: ~150-250 lines (3-state FSM, rr priority encoder, two counters).
// TESTING
//  1 Reset with req=0 for 5 cycles -> sel=0, mux_dis=1, gnt=0, sw_cnt=0 and all stay constant.
//  2 req=0x0020 from IDLE, sel=0, SETTLE=2:
//    -> sel=5 after 1 cycle; gnt=0x0020 and mux_dis=0 after 3 cycles; sw_cnt=1.
//  3 Release and re-assert req=0x0020:
//    -> re-grant after 1 cycle; no sel change; sw_cnt stays 1.
//  4 req=0x0208 held, MAX_HOLD=8:
//    -> grants alternate 3,9,3,9; each grant lasts 8 cycles, followed by 1+SETTLE gap cycles
//       with mux_dis=1; sw_cnt increments on every swap.
//  5 req=0x0001 alone held for 40 cycles -> continuous grant to 0; no gap, no sel change.
//  6 rst pulsed during GRANT of input 7 -> mux_dis=1, gnt=0, sel=0 in the same cycle;
//    after rst drops, input 7 is re-granted via SWITCH.
//  7 Force sw_cnt to all-ones (CNT_W=4 build, 16 swaps) -> stays 0xF;
//    cnt_clr on the same cycle as a swap -> 0.

Source files
------------

// File: rtl/cm150_sel_scheduler.sv
// ---------------------------------------------------------------------------
// cm150_sel_scheduler
//
// Round-robin scheduler that shares one 16:1 mux among 16 requesters.
// It drives the mux select lines and its disable line, and only moves the
// select lines when the grant changes owner.
//
// While the select lines settle after a change, the mux is held disabled.
// This keeps glitched data away from the consumer. Every select change is
// counted, so the switching activity of the shared mux can be measured.
//
// Parameters
//   SETTLE   cycles mux_dis stays high after sel changes, before a grant (>=1)
//   MAX_HOLD max consecutive grant cycles while another requester waits (>=1)
//   CNT_W    width of the saturating select-change counter
//
// Ports
//   clk      in   1      rising-edge clock
//   rst      in   1      asynchronous reset, active-high
//   req      in   16     request per mux data input; bit i requests input i
//   cnt_clr  in   1      synchronous clear of sw_cnt (wins over an increment)
//   sel      out  4      mux select {t,s,r,q}; q is the LSB
//   mux_dis  out  1      mux enable u; 1 forces the mux output inactive
//   gnt      out  16     one-hot grant; bit sel is set while granted
//   gnt_vld  out  1      1 while a grant is active (always ~mux_dis)
//   sw_cnt   out  CNT_W  saturating count of sel value changes
// ---------------------------------------------------------------------------
module cm150_sel_scheduler #(
  parameter int SETTLE   = 2,
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      req,
  input  logic             cnt_clr,
  output logic [3:0]       sel,
  output logic             mux_dis,
  output logic [15:0]      gnt,
  output logic             gnt_vld,
  output logic [CNT_W-1:0] sw_cnt
);

  // The settle counter holds at most SETTLE-1. The hold counter holds at
  // most MAX_HOLD.
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int HW = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SWITCH = 2'd1,
    GRANT  = 2'd2
  } state_t;

  // State registers
  state_t           state;
  logic [3:0]       ptr;
  logic [HW-1:0]    hold_cnt;
  logic [SW-1:0]    settle_cnt;

  // Next-state values
  state_t           state_n;
  logic [3:0]       ptr_n;
  logic [HW-1:0]    hold_n;
  logic [SW-1:0]    settle_n;
  logic [3:0]       sel_n;
  logic             mux_dis_n;
  logic [15:0]      gnt_n;
  logic             gnt_vld_n;
  logic [CNT_W-1:0] sw_cnt_n;

  // Arbitration helpers
  logic [3:0]       ofs;
  logic [3:0]       winner;
  logic             any_req;
  logic [15:0]      sel_onehot;
  logic             others;
  logic             hold_expire;
  logic             sel_change;

  assign any_req    = |req;
  assign sel_onehot = 16'b1 << sel;

  // A requester other than the current owner is waiting.
  assign others = |(req & ~sel_onehot);

  // The counter reaches 0 on this cycle's decrement.
  assign hold_expire = (hold_cnt == HW'(1));

  // Round-robin priority encoder.
  // The scan runs downward, so the lowest offset from ptr with a request
  // is the one left in ofs. The 4-bit sum wraps modulo 16.
  always_comb begin
    ofs = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (req[ptr + 4'(i)]) ofs = 4'(i);
    end
    winner = ptr + ofs;
  end

  // Next-state and registered-output logic
  always_comb begin
    // NOTE: every variable gets a default here first, so no path through the
    // case statement leaves one unassigned and infers a latch.
    state_n    = state;
    ptr_n      = ptr;
    hold_n     = hold_cnt;
    settle_n   = settle_cnt;
    sel_n      = sel;
    mux_dis_n  = mux_dis;
    gnt_n      = gnt;
    gnt_vld_n  = gnt_vld;
    sel_change = 1'b0;

    unique case (state)
      IDLE: begin
        if (any_req) begin
          if (winner == sel) begin
            // Select lines already point at the winner: grant at once.
            state_n   = GRANT;
            gnt_n     = sel_onehot;
            mux_dis_n = 1'b0;
            gnt_vld_n = 1'b1;
            hold_n    = HW'(MAX_HOLD);
          end else begin
            // Move the select lines and keep the mux disabled while they
            // settle. The winner is now fixed until the grant.
            state_n    = SWITCH;
            sel_n      = winner;
            sel_change = 1'b1;
            settle_n   = SW'(SETTLE - 1);
          end
        end
      end

      SWITCH: begin
        if (settle_cnt == '0) begin
          state_n   = GRANT;
          gnt_n     = sel_onehot;
          mux_dis_n = 1'b0;
          gnt_vld_n = 1'b1;
          hold_n    = HW'(MAX_HOLD);
        end else begin
          settle_n = settle_cnt - SW'(1);
        end
      end

      GRANT: begin
        // A dropped request and a hold expiry on the same cycle are one exit.
        if (!req[sel] || (hold_expire && others)) begin
          state_n   = IDLE;
          gnt_n     = '0;
          mux_dis_n = 1'b1;
          gnt_vld_n = 1'b0;
          ptr_n     = sel + 4'd1;
        end else if (hold_expire) begin
          // Nobody else is waiting: reload and keep the grant without a gap.
          hold_n = HW'(MAX_HOLD);
        end else begin
          hold_n = hold_cnt - HW'(1);
        end
      end

      default: begin
        state_n   = IDLE;
        gnt_n     = '0;
        mux_dis_n = 1'b1;
        gnt_vld_n = 1'b0;
      end
    endcase

    // Select-change counter: a clear wins, and an increment saturates.
    if (cnt_clr) begin
      sw_cnt_n = '0;
    end else if (sel_change && !(&sw_cnt)) begin
      sw_cnt_n = sw_cnt + CNT_W'(1);
    end else begin
      sw_cnt_n = sw_cnt;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= 4'd0;
      hold_cnt   <= '0;
      settle_cnt <= '0;
      sel        <= 4'd0;
      mux_dis    <= 1'b1;
      gnt        <= '0;
      gnt_vld    <= 1'b0;
      sw_cnt     <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments. Every register
      // then updates from values sampled before the edge, whatever order the
      // statements are written in.
      state      <= state_n;
      ptr        <= ptr_n;
      hold_cnt   <= hold_n;
      settle_cnt <= settle_n;
      sel        <= sel_n;
      mux_dis    <= mux_dis_n;
      gnt        <= gnt_n;
      gnt_vld    <= gnt_vld_n;
      sw_cnt     <= sw_cnt_n;
    end
  end

  // Structural invariants of the scheduler
  a_gnt_onehot : assert property (@(posedge clk) disable iff (rst)
    $onehot0(gnt));

  a_gnt_matches_sel : assert property (@(posedge clk) disable iff (rst)
    gnt_vld |-> (gnt == sel_onehot));

  a_vld_is_not_dis : assert property (@(posedge clk) disable iff (rst)
    gnt_vld == !mux_dis);

  a_sel_stable_when_enabled : assert property (@(posedge clk) disable iff (rst)
    !mux_dis |-> $stable(sel));

endmodule

// File: tb/tb_cm150_sel_scheduler.sv
// ---------------------------------------------------------------------------
// tb_cm150_sel_scheduler
//
// Directed, table-driven bench for cm150_sel_scheduler.
//
// Each table record holds the inputs for one clock and the registered outputs
// expected right after that edge. The records cover reset idle, a first grant
// through SWITCH, a re-grant without a select change, round-robin alternation
// with hold expiry, a continuous single-owner grant, and a counter clear.
//
// Hand-written sequences cover the asynchronous reset mid-grant. A second
// instance (CNT_W=4, MAX_HOLD=1) covers counter saturation and a clear that
// lands on the same cycle as a swap.
// ---------------------------------------------------------------------------
module tb_cm150_sel_scheduler;

  typedef struct {
    logic [15:0] req;
    logic        clr;
    logic [3:0]  sel;
    logic        dis;
    logic [15:0] gnt;
    logic [15:0] cnt;
  } vec_t;

  logic        clk;
  logic        rst;

  // Main instance: default parameters
  logic [15:0] req;
  logic        cnt_clr;
  logic [3:0]  sel;
  logic        mux_dis;
  logic [15:0] gnt;
  logic        gnt_vld;
  logic [15:0] sw_cnt;

  // Counter instance: CNT_W=4, MAX_HOLD=1 so swaps come every 4 cycles
  logic [15:0] req2;
  logic        cnt_clr2;
  logic [3:0]  sel2;
  logic        mux_dis2;
  logic [15:0] gnt2;
  logic        gnt_vld2;
  logic [3:0]  sw_cnt2;

  int n_checks = 0;
  int n_fail   = 0;

  vec_t vecs[$];

  cm150_sel_scheduler #(.SETTLE(2), .MAX_HOLD(8), .CNT_W(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .cnt_clr (cnt_clr),
    .sel     (sel),
    .mux_dis (mux_dis),
    .gnt     (gnt),
    .gnt_vld (gnt_vld),
    .sw_cnt  (sw_cnt)
  );

  cm150_sel_scheduler #(.SETTLE(2), .MAX_HOLD(1), .CNT_W(4)) dut_c4 (
    .clk     (clk),
    .rst     (rst),
    .req     (req2),
    .cnt_clr (cnt_clr2),
    .sel     (sel2),
    .mux_dis (mux_dis2),
    .gnt     (gnt2),
    .gnt_vld (gnt_vld2),
    .sw_cnt  (sw_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: outputs are sampled 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input logic [15:0] r, input logic c, input logic [3:0] s,
                              input logic d, input logic [15:0] g, input logic [15:0] n);
    vec_t v;
    v.req = r; v.clr = c; v.sel = s; v.dis = d; v.gnt = g; v.cnt = n;
    vecs.push_back(v);
  endfunction

  initial begin
    logic [3:0]  s;
    logic [15:0] c;

    // ---------------- vector table ----------------
    // Reset release, req idle for 5 cycles
    repeat (5) add(16'h0000, 0, 4'd0, 1, 16'h0000, 16'd0);

    // req=0x0020 from sel=0: sel moves at once, grant after SETTLE+1
    add(16'h0020, 0, 4'd5, 1, 16'h0000, 16'd1);
    add(16'h0020, 0, 4'd5, 1, 16'h0000, 16'd1);
    add(16'h0020, 0, 4'd5, 0, 16'h0020, 16'd1);
    add(16'h0020, 0, 4'd5, 0, 16'h0020, 16'd1);

    // Release, then re-assert: re-grant after 1 cycle, no select change
    add(16'h0000, 0, 4'd5, 1, 16'h0000, 16'd1);
    add(16'h0000, 0, 4'd5, 1, 16'h0000, 16'd1);
    add(16'h0020, 0, 4'd5, 0, 16'h0020, 16'd1);

    // req=0x0208: drop of req[5] exits; then grants alternate 9,3,9,3,
    // each lasting 8 cycles, separated by IDLE + 2 SWITCH cycles
    add(16'h0208, 0, 4'd5, 1, 16'h0000, 16'd1);
    for (int k = 0; k < 4; k++) begin
      s = (k % 2 == 0) ? 4'd9 : 4'd3;
      c = 16'(2 + k);
      repeat (2) add(16'h0208, 0, s, 1, 16'h0000, c);
      repeat (8) add(16'h0208, 0, s, 0, 16'h0001 << s, c);
      if (k < 3) add(16'h0208, 0, s, 1, 16'h0000, c);
    end

    // req=0x0001 alone: exit from 3, one swap, then 40 gap-free grant cycles
    add(16'h0001, 0, 4'd3, 1, 16'h0000, 16'd5);
    repeat (2)  add(16'h0001, 0, 4'd0, 1, 16'h0000, 16'd6);
    repeat (40) add(16'h0001, 0, 4'd0, 0, 16'h0001, 16'd6);

    // Counter clear during a grant
    add(16'h0001, 1, 4'd0, 0, 16'h0001, 16'd0);
    add(16'h0001, 0, 4'd0, 0, 16'h0001, 16'd0);

    // ---------------- reset ----------------
    rst      = 1'b1;
    req      = '0;
    cnt_clr  = 1'b0;
    req2     = '0;
    cnt_clr2 = 1'b0;
    step();
    step();
    check("reset sel",     32'(sel),     32'd0);
    check("reset mux_dis", 32'(mux_dis), 32'd1);
    check("reset gnt",     32'(gnt),     32'd0);
    check("reset gnt_vld", 32'(gnt_vld), 32'd0);
    check("reset sw_cnt",  32'(sw_cnt),  32'd0);
    rst = 1'b0;

    // ---------------- table run ----------------
    foreach (vecs[i]) begin
      req     = vecs[i].req;
      cnt_clr = vecs[i].clr;
      step();
      check($sformatf("v%0d sel", i),     32'(sel),     32'(vecs[i].sel));
      check($sformatf("v%0d mux_dis", i), 32'(mux_dis), 32'(vecs[i].dis));
      check($sformatf("v%0d gnt", i),     32'(gnt),     32'(vecs[i].gnt));
      check($sformatf("v%0d gnt_vld", i), 32'(gnt_vld), 32'(!vecs[i].dis));
      check($sformatf("v%0d sw_cnt", i),  32'(sw_cnt),  32'(vecs[i].cnt));
    end
    cnt_clr = 1'b0;

    // ---------------- reset mid-grant of input 7 ----------------
    req = 16'h0080;
    step();                                   // req[0] dropped -> IDLE
    check("r7 exit mux_dis", 32'(mux_dis), 32'd1);
    step();                                   // IDLE -> SWITCH, sel=7
    check("r7 sel",    32'(sel),    32'd7);
    check("r7 sw_cnt", 32'(sw_cnt), 32'd1);
    step();
    step();                                   // GRANT
    check("r7 gnt",     32'(gnt),     32'h80);
    check("r7 mux_dis", 32'(mux_dis), 32'd0);
    #3 rst = 1'b1;                            // mid-cycle, no clock edge
    #1;
    check("async rst sel",     32'(sel),     32'd0);
    check("async rst mux_dis", 32'(mux_dis), 32'd1);
    check("async rst gnt",     32'(gnt),     32'd0);
    check("async rst gnt_vld", 32'(gnt_vld), 32'd0);
    check("async rst sw_cnt",  32'(sw_cnt),  32'd0);
    step();
    rst = 1'b0;
    step();                                   // re-arbitrate: 7 != 0 -> SWITCH
    check("post rst sel",     32'(sel),     32'd7);
    check("post rst mux_dis", 32'(mux_dis), 32'd1);
    check("post rst sw_cnt",  32'(sw_cnt),  32'd1);
    step();
    check("post rst settle gnt", 32'(gnt), 32'd0);
    step();
    check("post rst gnt",     32'(gnt),     32'h80);
    check("post rst mux_dis", 32'(mux_dis), 32'd0);

    // ---------------- saturation on the CNT_W=4 instance ----------------
    // req=0x0003 with MAX_HOLD=1: direct grant to 0, then a swap every
    // 4 edges starting at edge 3, so the count is n at edge 4n-1.
    req2 = 16'h0003;
    repeat (20) step();
    check("c4 cnt at 20", 32'(sw_cnt2),   32'd5);
    check("c4 sel at 20", 32'(sel2),      32'd1);
    check("c4 dis at 20", 32'(mux_dis2),  32'd1);
    repeat (60) step();
    check("c4 saturated", 32'(sw_cnt2), 32'hF);
    repeat (9) step();
    check("c4 still saturated", 32'(sw_cnt2), 32'hF);
    req2 = 16'h0000;
    repeat (8) step();
    check("c4 idle count", 32'(sw_cnt2),  32'hF);
    check("c4 idle dis",   32'(mux_dis2), 32'd1);
    req2     = 16'h0004;                      // swap to 2 and clear together
    cnt_clr2 = 1'b1;
    step();
    check("c4 clr+swap sel", 32'(sel2),    32'd2);
    check("c4 clr+swap cnt", 32'(sw_cnt2), 32'd0);
    cnt_clr2 = 1'b0;
    step();
    check("c4 after clr cnt", 32'(sw_cnt2),  32'd0);
    check("c4 after clr dis", 32'(mux_dis2), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
